// File: rtl/scan_chain.sv
// Serial scan-chain controller: 25-bit shift chain between a 5-pin pad interface and chip config/status.
// Optional macro SCAN_INPUT_SYNC_EN adds a 2-flop synchronizer on every pad input (+1 clock latency).
module scan_chain #(
  parameter int CHAIN_LEN = 25,
  parameter int ARR_AW    = 2,
  parameter int ARR_DW    = 4
) (
  input  logic                          scan_clk,
  input  logic                          scan_rst_n,
  input  logic                          scan_phi,
  input  logic                          scan_phi_bar,
  input  logic                          scan_data_in,
  output logic                          scan_data_out,
  input  logic                          scan_load_chip,
  input  logic                          scan_load_chain,
  output logic                          scan_reset,
  output logic                          write_data_1,
  output logic [1:0]                    write_data_2,
  output logic [2:0]                    write_data_3,
  output logic [(1<<ARR_AW)*ARR_DW-1:0] write_data_array,
  input  logic                          read_data_1,
  input  logic [1:0]                    read_data_2,
  input  logic [2:0]                    read_data_3,
  input  logic [(1<<ARR_AW)*ARR_DW-1:0] read_data_array
);

  localparam int NENT = 1 << ARR_AW;
  localparam int NPAD = 5;
  localparam int P_PHI = 0, P_PHIB = 1, P_DIN = 2, P_LCHIP = 3, P_LCHAIN = 4;

  logic [NPAD-1:0] pad_raw, pad_q, prev_q, pad_rise;
  assign pad_raw = {scan_load_chain, scan_load_chip, scan_data_in, scan_phi_bar, scan_phi};

`ifdef SCAN_INPUT_SYNC_EN
  logic [NPAD-1:0] meta_q;
  always_ff @(posedge scan_clk or negedge scan_rst_n) begin
    if (!scan_rst_n) begin
      meta_q <= '0;
      pad_q  <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= pad_raw;
      pad_q  <= meta_q;
      prev_q <= pad_q;
    end
  end
`else
  always_ff @(posedge scan_clk or negedge scan_rst_n) begin
    if (!scan_rst_n) begin
      pad_q  <= '0;
      prev_q <= '0;
    end else begin
      pad_q  <= pad_raw;
      prev_q <= pad_q;
    end
  end
`endif

  assign pad_rise = pad_q & ~prev_q;

  logic [CHAIN_LEN-1:0] chain_q, chain_d;
  logic                 master_q, master_d;
  logic                 rst_q, rst_d, wd1_q, wd1_d;
  logic [1:0]           wd2_q, wd2_d;
  logic [2:0]           wd3_q, wd3_d;
  logic [NENT*ARR_DW-1:0] wda_q, wda_d;

  logic [ARR_DW-1:0] wda_entry [NENT];
  logic [ARR_DW-1:0] rda_entry [NENT];

  generate
    for (genvar gi = 0; gi < NENT; gi++) begin : g_entry
      assign wda_entry[gi] = wda_q[gi*ARR_DW +: ARR_DW];
      assign rda_entry[gi] = read_data_array[gi*ARR_DW +: ARR_DW];
    end
  endgenerate

  logic [ARR_AW-1:0] waddr, raddr;
  logic [ARR_DW-1:0] wdata;
  assign waddr = chain_q[8:7];
  assign wdata = chain_q[12:9];
  assign raddr = chain_q[20:19];

  // Chain and master bit; a phi_bar edge shifts the master as it stood before this cycle.
  always_comb begin
    chain_d  = chain_q;
    master_d = master_q;
    if (pad_rise[P_PHI]) master_d = pad_q[P_DIN];
    if (pad_rise[P_PHIB]) begin
      if (pad_q[P_LCHAIN]) begin
        chain_d[0]     = rst_q;
        chain_d[1]     = wd1_q;
        chain_d[3:2]   = wd2_q;
        chain_d[6:4]   = wd3_q;
        chain_d[12:9]  = wda_entry[waddr];
        chain_d[13]    = read_data_1;
        chain_d[15:14] = read_data_2;
        chain_d[18:16] = read_data_3;
        chain_d[24:21] = rda_entry[raddr];
      end else begin
        chain_d = {master_q, chain_q[CHAIN_LEN-1:1]};
      end
    end
  end

  // Chip-side registers always load from the pre-update chain.
  always_comb begin
    rst_d = rst_q;
    wd1_d = wd1_q;
    wd2_d = wd2_q;
    wd3_d = wd3_q;
    wda_d = wda_q;
    if (pad_rise[P_LCHIP]) begin
      if (chain_q[0]) begin
        rst_d = 1'b1;
        wd1_d = 1'b0;
        wd2_d = '0;
        wd3_d = '0;
        wda_d = '0;
      end else begin
        rst_d = 1'b0;
        wd1_d = chain_q[1];
        wd2_d = chain_q[3:2];
        wd3_d = chain_q[6:4];
        for (int k = 0; k < NENT; k++) begin
          if (waddr == ARR_AW'(k)) wda_d[k*ARR_DW +: ARR_DW] = wdata;
        end
      end
    end
  end

  always_ff @(posedge scan_clk or negedge scan_rst_n) begin
    if (!scan_rst_n) begin
      chain_q  <= '0;
      master_q <= 1'b0;
      rst_q    <= 1'b0;
      wd1_q    <= 1'b0;
      wd2_q    <= '0;
      wd3_q    <= '0;
      wda_q    <= '0;
    end else begin
      chain_q  <= chain_d;
      master_q <= master_d;
      rst_q    <= rst_d;
      wd1_q    <= wd1_d;
      wd2_q    <= wd2_d;
      wd3_q    <= wd3_d;
      wda_q    <= wda_d;
    end
  end

  assign scan_data_out    = chain_q[0];
  assign scan_reset       = rst_q;
  assign write_data_1     = wd1_q;
  assign write_data_2     = wd2_q;
  assign write_data_3     = wd3_q;
  assign write_data_array = wda_q;

endmodule

// File: tb/tb_scan_chain.sv
// Directed self-checking bench for scan_chain: reset, soft reset, write, readback, passthrough, same-cycle load.
module tb_scan_chain;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        phi, phi_bar, din, load_chip, load_chain;
  logic        dout, sreset, wd1;
  logic [1:0]  wd2, rd2;
  logic [2:0]  wd3, rd3;
  logic [15:0] wda, rda;
  logic        rd1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  scan_chain dut (
    .scan_clk(clk), .scan_rst_n(rst_n),
    .scan_phi(phi), .scan_phi_bar(phi_bar), .scan_data_in(din), .scan_data_out(dout),
    .scan_load_chip(load_chip), .scan_load_chain(load_chain),
    .scan_reset(sreset), .write_data_1(wd1), .write_data_2(wd2), .write_data_3(wd3),
    .write_data_array(wda),
    .read_data_1(rd1), .read_data_2(rd2), .read_data_3(rd3), .read_data_array(rda)
  );

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One phi then phi_bar pulse; each level held 3 clocks.
  task automatic shift_bit(input logic b, output logic out_bit);
    out_bit = dout;
    din = b;
    phi = 1'b1;     hold(3);
    phi = 1'b0;     hold(3);
    phi_bar = 1'b1; hold(3);
    phi_bar = 1'b0; hold(3);
  endtask

  task automatic shift_word(input logic [24:0] w, output logic [24:0] out_w);
    logic b;
    for (int i = 0; i < 25; i++) begin
      shift_bit(w[i], b);
      out_w[i] = b;
    end
  endtask

  task automatic pulse_load_chip();
    load_chip = 1'b1; hold(3);
    load_chip = 1'b0; hold(4);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    phi = 0; phi_bar = 0; din = 0; load_chip = 0; load_chain = 0;
    rd1 = 0; rd2 = 0; rd3 = 0; rda = 16'h0;
    hold(3);
    checks++; if (sreset !== 1'b0) begin errors++; $display("FAIL reset_scan_reset got %b want 0", sreset); end
    checks++; if (wd1 !== 1'b0) begin errors++; $display("FAIL reset_wd1 got %b want 0", wd1); end
    checks++; if (wd2 !== 2'd0) begin errors++; $display("FAIL reset_wd2 got %0d want 0", wd2); end
    checks++; if (wd3 !== 3'd0) begin errors++; $display("FAIL reset_wd3 got %0d want 0", wd3); end
    checks++; if (wda !== 16'h0) begin errors++; $display("FAIL reset_wda got %h want 0000", wda); end
    checks++; if (dout !== 1'b0) begin errors++; $display("FAIL reset_dout got %b want 0", dout); end
    rst_n = 1'b1;
    hold(2);
    $display("reset: outputs sreset=%b wd1=%b wd2=%0d wd3=%0d wda=%h dout=%b", sreset, wd1, wd2, wd3, wda, dout);
  endtask

  task automatic test_write();
    logic [24:0] w, o;
    // array data A, addr 2, wd3=3, wd2=2, wd1=1, scan_reset=0
    w = {12'h000, 4'hA, 2'd2, 3'd3, 2'd2, 1'b1, 1'b0};
    shift_word(w, o);
    pulse_load_chip();
    checks++; if (wd1 !== 1'b1) begin errors++; $display("FAIL write_wd1 got %b want 1", wd1); end
    checks++; if (wd2 !== 2'd2) begin errors++; $display("FAIL write_wd2 got %0d want 2", wd2); end
    checks++; if (wd3 !== 3'd3) begin errors++; $display("FAIL write_wd3 got %0d want 3", wd3); end
    checks++; if (wda !== 16'h0A00) begin errors++; $display("FAIL write_wda got %h want 0a00", wda); end
    checks++; if (sreset !== 1'b0) begin errors++; $display("FAIL write_sreset got %b want 0", sreset); end
    $display("write: wd1=%b wd2=%0d wd3=%0d wda=%h sreset=%b", wd1, wd2, wd3, wda, sreset);
  endtask

  task automatic test_soft_reset();
    logic [24:0] w, o;
    w = {12'h000, 4'hF, 2'd1, 3'd7, 2'd3, 1'b1, 1'b1};
    shift_word(w, o);
    pulse_load_chip();
    checks++; if (sreset !== 1'b1) begin errors++; $display("FAIL soft_sreset got %b want 1", sreset); end
    checks++; if (wda !== 16'h0000) begin errors++; $display("FAIL soft_wda got %h want 0000", wda); end
    checks++; if ({wd3, wd2, wd1} !== 6'd0) begin errors++; $display("FAIL soft_wd got %h want 00", {wd3, wd2, wd1}); end
    $display("soft_reset: sreset=%b wda=%h wd=%h", sreset, wda, {wd3, wd2, wd1});
  endtask

  task automatic test_readback();
    logic [24:0] w, o, exp_w;
    logic b;
    rd1 = 1'b0; rd2 = 2'd3; rd3 = 3'd5; rda = 16'hABCD;
    // read addr 1, write addr 2
    w = {4'h0, 2'd1, 3'd0, 2'd0, 1'b0, 4'h0, 2'd2, 3'd0, 2'd0, 1'b0, 1'b0};
    shift_word(w, o);
    load_chain = 1'b1;
    shift_bit(1'b0, b);
    load_chain = 1'b0;
    shift_word(25'h0, o);
    exp_w = {4'hC, 2'd1, 3'd5, 2'd3, 1'b0, 4'hA, 2'd2, 3'd3, 2'd2, 1'b1, 1'b0};
    checks++; if (o[1] !== 1'b1) begin errors++; $display("FAIL rb_wd1 got %b want 1", o[1]); end
    checks++; if (o[3:2] !== 2'd2) begin errors++; $display("FAIL rb_wd2 got %0d want 2", o[3:2]); end
    checks++; if (o[6:4] !== 3'd3) begin errors++; $display("FAIL rb_wd3 got %0d want 3", o[6:4]); end
    checks++; if (o[12:9] !== 4'hA) begin errors++; $display("FAIL rb_wdata got %h want a", o[12:9]); end
    checks++; if (o[13] !== 1'b0) begin errors++; $display("FAIL rb_rd1 got %b want 0", o[13]); end
    checks++; if (o[15:14] !== 2'd3) begin errors++; $display("FAIL rb_rd2 got %0d want 3", o[15:14]); end
    checks++; if (o[18:16] !== 3'd5) begin errors++; $display("FAIL rb_rd3 got %0d want 5", o[18:16]); end
    checks++; if (o[24:21] !== 4'hC) begin errors++; $display("FAIL rb_rdata got %h want c", o[24:21]); end
    checks++; if (o !== exp_w) begin errors++; $display("FAIL rb_word got %h want %h", o, exp_w); end
    $display("readback: word=%h", o);
  endtask

  task automatic test_passthrough();
    logic [24:0] w1, w2, o;
    w1 = 25'($urandom);
    w2 = 25'($urandom);
    shift_word(w1, o);
    shift_word(w2, o);
    checks++; if (o !== w1) begin errors++; $display("FAIL pass_word got %h want %h", o, w1); end
    $display("passthrough: in=%h out=%h", w1, o);
  endtask

  task automatic test_same_cycle();
    logic [24:0] w, o;
    // data 5, addr 3, wd3=6, wd2=1, wd1=0, scan_reset=0; a one-step shift would give wd1=1
    w = {12'h000, 4'h5, 2'd3, 3'd6, 2'd1, 1'b0, 1'b0};
    shift_word(w, o);
    din = 1'b0;
    phi = 1'b1; hold(3);
    phi = 1'b0; hold(3);
    phi_bar = 1'b1; load_chip = 1'b1; hold(3);
    phi_bar = 1'b0; load_chip = 1'b0; hold(4);
    checks++; if (wd1 !== 1'b0) begin errors++; $display("FAIL same_wd1 got %b want 0", wd1); end
    checks++; if (wd2 !== 2'd1) begin errors++; $display("FAIL same_wd2 got %0d want 1", wd2); end
    checks++; if (wd3 !== 3'd6) begin errors++; $display("FAIL same_wd3 got %0d want 6", wd3); end
    checks++; if (wda !== 16'h5A00) begin errors++; $display("FAIL same_wda got %h want 5a00", wda); end
    checks++; if (sreset !== 1'b0) begin errors++; $display("FAIL same_sreset got %b want 0", sreset); end
    $display("same_cycle: wd1=%b wd2=%0d wd3=%0d wda=%h", wd1, wd2, wd3, wda);
  endtask

  initial begin
    test_reset();
    test_write();
    test_soft_reset();
    test_write();
    test_readback();
    test_passthrough();
    test_same_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/scan_chain.md
Name: scan_chain

Overview:
- Single-clock, serial scan-chain controller bridging a 5-pin pad scan interface and chip-internal configuration/status signals.
- Bits are shifted serially through a 25-bit chain.
- A load-chip strobe copies writable fields into chip-side registers.
- A load-chain strobe captures chip-side and readable values back into the chain for shift-out.

Parameters:
- CHAIN_LEN, 25, total chain bits; field map below is fixed for this length.
- ARR_AW, 2, address width of both arrays (4 entries).
- ARR_DW, 4, data width per array entry.

Ports:
- scan_clk  in  1  system clock.
- scan_rst_n  in  1  asynchronous active-low reset.
- scan_phi  in  1  pad shift phase 1; rising edge captures scan_data_in into master bit.
- scan_phi_bar  in  1  pad shift phase 2; rising edge shifts chain or performs parallel capture.
- scan_data_in  in  1  serial data in.
- scan_data_out  out  1  serial data out, equals chain[0].
- scan_load_chip  in  1  rising edge updates chip-side writable registers.
- scan_load_chain  in  1  level; selects parallel capture on next phi_bar edge.
- scan_reset  out  1  chip-side soft reset flag.
- write_data_1  out  1  chip-side config.
- write_data_2  out  2  chip-side config.
- write_data_3  out  3  chip-side config.
- write_data_array  out  16  4x4 config array, entry k at bits [4k+3:4k].
- read_data_1  in  1  chip status.
- read_data_2  in  2  chip status.
- read_data_3  in  3  chip status.
- read_data_array  in  16  4x4 status array, same packing.

Behaviour:
Chain field map (bit index):
- scan_reset [0]
- write_data_1 [1]
- write_data_2 [3:2]
- write_data_3 [6:4]
- write_data_array addr [8:7], data [12:9]
- read_data_1 [13]
- read_data_2 [15:14]
- read_data_3 [18:16]
- read_data_array addr [20:19], data [24:21]

Reset (scan_rst_n low):
- Chain, master bit, all outputs and all input-stage flops cleared to 0.

Input stage:
- Pad inputs scan_phi, scan_phi_bar, scan_data_in, scan_load_chip, scan_load_chain registered once, then rising-edge detected.

Shift:
- phi rising edge: master <= scan_data_in.
- phi_bar rising edge with load_chain = 0: chain[i] <= chain[i+1], chain[24] <= master.
- Bit 0 of the host word is shifted in first; after 25 shifts, host bit i sits in chain[i].
- Data shifted out first corresponds to chain bit 0.

Parallel capture (phi_bar rising edge with load_chain = 1):
- Write fields <= current chip-side outputs.
- write_data_array data field <= write_data_array entry[addr field]; addr field kept.
- read_data_1/2/3 fields <= inputs.
- read_data_array data field <= read_data_array entry[addr field]; addr field kept.

Load chip (scan_load_chip rising edge):
- If chain[0] = 1: scan_reset <= 1; write_data_1/2/3 and whole write_data_array <= 0.
- Else: scan_reset <= 0; write_data_1/2/3 <= their fields; write_data_array entry[addr] <= data field; other entries unchanged.

Edge cases:
- Simultaneous load_chip and phi_bar edges: load_chip uses pre-update chain contents.
- phi_bar edge without a preceding phi edge: shifts the stale master bit.
- Pad pulses must be held at least 3 clocks.
- Latency: pad edge to chain/output update is 2 clocks (3 with the optional feature).
- scan_data_out is combinational from chain[0].

Optional Feature:
- Macro SCAN_INPUT_SYNC_EN.
- Defined: every pad input passes through a 2-flop synchronizer before edge detection; latency +1 clock.
- Undefined: single register stage only; pads must be synchronous to scan_clk.

Test Plan:
- Reset: assert scan_rst_n low -> all outputs 0, scan_data_out 0.
- Soft reset: shift word with bit0 = 1, pulse load_chip -> scan_reset = 1, write_data_array = 16'h0000.
- Write: shift scan_reset = 0, wd1 = 1, wd2 = 2, wd3 = 3, array addr 2 data 4'hA; pulse load_chip -> write_data_1 = 1, write_data_2 = 2, write_data_3 = 3, write_data_array = 16'h0A00.
- Readback: drive read_data_1 = 0, read_data_2 = 3, read_data_3 = 5, read_data_array = 16'hABCD; shift with read addr = 1; load_chain (one phi/phi_bar pulse); shift 25 -> fields wd1 = 1, wd2 = 2, wd3 = 3, rd1 = 0, rd2 = 3, rd3 = 5, rd array data = 4'hC.
- Passthrough: shift 25 random bits twice without loads -> the second shift-out equals the first word.
- Same-cycle load_chip and phi_bar edge -> outputs reflect pre-shift chain.
